// File: rtl/cmos_pkg.sv
// Shared types and constants for the PCF8583-style CMOS RAM/RTC I2C responder.
package cmos_pkg;

    typedef enum logic [2:0] {
        IDLE,
        DEVADDR,
        ACK_DEV,
        WORD,
        WRITE,
        READ,
        IGNORE
    } state_t;

    localparam logic [6:0] DEV_ADDR_DEFAULT = 7'h50;

    localparam logic [7:0] RTC_CTRL = 8'd0;
    localparam logic [7:0] RTC_SEC  = 8'd2;
    localparam logic [7:0] RTC_MIN  = 8'd3;
    localparam logic [7:0] RTC_HOUR = 8'd4;

    localparam logic [7:0] BCD_MAX_MS = 8'h59;
    localparam logic [7:0] BCD_MAX_HR = 8'h23;

    // Returns {carry, next}; carry is set when the value wraps back to 00.
    function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] lim);
        logic [8:0] r;
        if (v >= lim) begin
            r = {1'b1, 8'h00};
        end else if (v[3:0] >= 4'h9) begin
            r = {1'b0, v[7:4] + 4'h1, 4'h0};
        end else begin
            r = {1'b0, v[7:4], v[3:0] + 4'h1};
        end
        return r;
    endfunction

endpackage

// File: rtl/cmos_i2c_slave_cond.sv
// I2C line conditioning: 2-flop synchroniser, 3-sample majority filter, edge/START/STOP pulses.
module i2c_cond (
    input  logic clk,
    input  logic rst_n,
    input  logic scl_i,
    input  logic sda_i,
    output logic sda,
    output logic scl_rise,
    output logic scl_fall,
    output logic start,
    output logic stop
);

    logic [1:0] scl_sync;
    logic [1:0] sda_sync;
    logic [2:0] scl_hist;
    logic [2:0] sda_hist;
    logic       scl_f;
    logic       scl_maj;
    logic       sda_maj;

    function automatic logic maj3(input logic [2:0] s);
        return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
    endfunction

    assign scl_maj = maj3(scl_hist);
    assign sda_maj = maj3(sda_hist);

    // Reset to the idle-bus level so leaving reset never looks like an edge.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            scl_sync <= '1;
            sda_sync <= '1;
            scl_hist <= '1;
            sda_hist <= '1;
            scl_f    <= 1'b1;
            sda      <= 1'b1;
            scl_rise <= 1'b0;
            scl_fall <= 1'b0;
            start    <= 1'b0;
            stop     <= 1'b0;
        end else begin
            scl_sync <= {scl_sync[0], scl_i};
            sda_sync <= {sda_sync[0], sda_i};
            scl_hist <= {scl_hist[1:0], scl_sync[1]};
            sda_hist <= {sda_hist[1:0], sda_sync[1]};
            scl_f    <= scl_maj;
            sda      <= sda_maj;
            scl_rise <= scl_maj & ~scl_f;
            scl_fall <= ~scl_maj & scl_f;
            start    <= scl_maj & scl_f & sda & ~sda_maj;
            stop     <= scl_maj & scl_f & ~sda & sda_maj;
        end
    end

endmodule

// File: rtl/cmos_i2c_slave.sv
// PCF8583-style 256-byte CMOS RAM on the IOC I2C bus, with a host preload port.
// Optional 1 Hz BCD clock on RAM[2..4] is enabled by defining CMOS_RTC_TICK_EN.
module cmos_i2c_slave
    import cmos_pkg::*;
#(
    parameter int unsigned CLKCPU   = 32000000,
    parameter logic [6:0]  DEV_ADDR = DEV_ADDR_DEFAULT
) (
    input  logic       clkcpu,
    input  logic       rst_n,
    input  logic       scl_i,
    input  logic       sda_i,
    output logic       sda_o,
    input  logic       host_we,
    input  logic [7:0] host_adr,
    input  logic [7:0] host_din,
    output logic [7:0] host_dout,
    output logic       busy
);

    logic       sda;
    logic       scl_rise;
    logic       scl_fall;
    logic       start;
    logic       stop;

    state_t     state;
    logic [2:0] bit_cnt;
    logic [7:0] shift;
    logic [7:0] ptr;
    logic       rw;
    logic       in_ack;
    logic       ack_drv;
    logic       rd_load;
    logic       wr_stb;
    logic [7:0] wr_data;
    logic [7:0] rx_byte;

    logic [7:0] mem [256];
    logic [7:0] ram_q;

    i2c_cond u_cond (
        .clk      (clkcpu),
        .rst_n    (rst_n),
        .scl_i    (scl_i),
        .sda_i    (sda_i),
        .sda      (sda),
        .scl_rise (scl_rise),
        .scl_fall (scl_fall),
        .start    (start),
        .stop     (stop)
    );

    assign rx_byte = {shift[6:0], sda};

    // in_ack marks the ninth clock of a byte; ack_drv tracks whether we are pulling SDA for it.
    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            state   <= IDLE;
            bit_cnt <= '0;
            shift   <= '0;
            ptr     <= '0;
            rw      <= 1'b0;
            in_ack  <= 1'b0;
            ack_drv <= 1'b0;
            rd_load <= 1'b0;
            sda_o   <= 1'b1;
            busy    <= 1'b0;
            wr_stb  <= 1'b0;
            wr_data <= '0;
        end else begin
            wr_stb <= 1'b0;
            if (start) begin
                state   <= DEVADDR;
                bit_cnt <= '0;
                busy    <= 1'b1;
                in_ack  <= 1'b0;
                ack_drv <= 1'b0;
                rd_load <= 1'b0;
            end else if (stop) begin
                state   <= IDLE;
                sda_o   <= 1'b1;
                busy    <= 1'b0;
                in_ack  <= 1'b0;
                ack_drv <= 1'b0;
                rd_load <= 1'b0;
            end else if (scl_rise) begin
                case (state)
                    DEVADDR: begin
                        shift <= rx_byte;
                        if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            if (rx_byte[7:1] == DEV_ADDR) begin
                                state <= ACK_DEV;
                                rw    <= rx_byte[0];
                            end else begin
                                state <= IGNORE;
                            end
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    WORD, WRITE: begin
                        if (!in_ack) begin
                            shift <= rx_byte;
                            if (bit_cnt == 3'd7) begin
                                bit_cnt <= '0;
                                in_ack  <= 1'b1;
                                if (state == WORD) begin
                                    ptr <= rx_byte;
                                end else begin
                                    wr_stb  <= 1'b1;
                                    wr_data <= rx_byte;
                                end
                            end else begin
                                bit_cnt <= bit_cnt + 3'd1;
                            end
                        end
                    end
                    READ: begin
                        if (in_ack) begin
                            in_ack <= 1'b0;
                            ptr    <= ptr + 8'd1;
                            if (sda) begin
                                state <= IGNORE;
                            end else begin
                                rd_load <= 1'b1;
                            end
                        end else if (bit_cnt == 3'd7) begin
                            bit_cnt <= '0;
                            in_ack  <= 1'b1;
                        end else begin
                            bit_cnt <= bit_cnt + 3'd1;
                        end
                    end
                    default: ;
                endcase
            end else if (scl_fall) begin
                case (state)
                    ACK_DEV: begin
                        if (!ack_drv) begin
                            sda_o   <= 1'b0;
                            ack_drv <= 1'b1;
                        end else begin
                            ack_drv <= 1'b0;
                            bit_cnt <= '0;
                            if (rw) begin
                                state <= READ;
                                sda_o <= ram_q[7];
                                shift <= {ram_q[6:0], 1'b0};
                            end else begin
                                state <= WORD;
                                sda_o <= 1'b1;
                            end
                        end
                    end
                    WORD, WRITE: begin
                        if (in_ack) begin
                            if (!ack_drv) begin
                                sda_o   <= 1'b0;
                                ack_drv <= 1'b1;
                            end else begin
                                sda_o   <= 1'b1;
                                ack_drv <= 1'b0;
                                in_ack  <= 1'b0;
                                if (state == WORD) begin
                                    state <= WRITE;
                                end else begin
                                    ptr <= ptr + 8'd1;
                                end
                            end
                        end
                    end
                    READ: begin
                        if (rd_load) begin
                            rd_load <= 1'b0;
                            sda_o   <= ram_q[7];
                            shift   <= {ram_q[6:0], 1'b0};
                        end else if (in_ack) begin
                            sda_o <= 1'b1;
                        end else begin
                            sda_o <= shift[7];
                            shift <= {shift[6:0], 1'b0};
                        end
                    end
                    default: sda_o <= 1'b1;
                endcase
            end
        end
    end

`ifdef CMOS_RTC_TICK_EN
    logic [31:0] pre_cnt;
    logic        pre_strobe;
    logic        rtc_pend;
    logic        rtc_upd;
    logic [8:0]  sec_nx;
    logic [8:0]  min_nx;
    logic [8:0]  hr_nx;

    assign pre_strobe = (pre_cnt == CLKCPU - 1);
    assign rtc_upd    = rtc_pend & ~busy & ~mem[RTC_CTRL][7];
    assign sec_nx     = bcd_inc(mem[RTC_SEC], BCD_MAX_MS);
    assign min_nx     = bcd_inc(mem[RTC_MIN], BCD_MAX_MS);
    assign hr_nx      = bcd_inc({2'b00, mem[RTC_HOUR][5:0]}, BCD_MAX_HR);

    // A strobe taken while busy stays pending; with the stop bit set it is simply dropped.
    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            pre_cnt  <= '0;
            rtc_pend <= 1'b0;
        end else begin
            pre_cnt  <= pre_strobe ? '0 : pre_cnt + 32'd1;
            rtc_pend <= pre_strobe | (rtc_pend & busy);
        end
    end
`endif

    // Write order sets priority: host lowest, then the clock, then I2C.
    always_ff @(posedge clkcpu) begin
        if (host_we) begin
            mem[host_adr] <= host_din;
        end
`ifdef CMOS_RTC_TICK_EN
        if (rtc_upd) begin
            mem[RTC_SEC] <= sec_nx[7:0];
            if (sec_nx[8]) begin
                mem[RTC_MIN] <= min_nx[7:0];
                if (min_nx[8]) begin
                    mem[RTC_HOUR] <= {mem[RTC_HOUR][7:6], hr_nx[5:0]};
                end
            end
        end
`endif
        if (wr_stb) begin
            mem[ptr] <= wr_data;
        end
        ram_q <= mem[ptr];
    end

    always_ff @(posedge clkcpu) begin
        if (!rst_n) begin
            host_dout <= '0;
        end else begin
            host_dout <= mem[host_adr];
        end
    end

endmodule

// File: tb/tb_cmos_i2c_slave.sv
// Directed + randomized bench for cmos_i2c_slave against a transaction-level RAM/pointer model.
module tb_cmos_i2c_slave;

`ifdef CMOS_RTC_TICK_EN
    localparam int unsigned HZ = 100;
`else
    localparam int unsigned HZ = 32000000;
`endif
    localparam int Q = 10;

    logic       clkcpu = 1'b0;
    logic       rst_n = 1'b0;
    logic       scl_i = 1'b1;
    logic       sda_i = 1'b1;
    logic       host_we = 1'b0;
    logic [7:0] host_adr = '0;
    logic [7:0] host_din = '0;
    logic       sda_o;
    logic       busy;
    logic [7:0] host_dout;

    logic [7:0] ref_mem [256];
    logic [7:0] ref_ptr;
    int         n_cmp = 0;
    int         n_err = 0;

    always #5 clkcpu = ~clkcpu;

    cmos_i2c_slave #(.CLKCPU(HZ), .DEV_ADDR(7'h50)) dut (
        .clkcpu    (clkcpu),
        .rst_n     (rst_n),
        .scl_i     (scl_i),
        .sda_i     (sda_i),
        .sda_o     (sda_o),
        .host_we   (host_we),
        .host_adr  (host_adr),
        .host_din  (host_din),
        .host_dout (host_dout),
        .busy      (busy)
    );

    task automatic tick(input int n);
        repeat (n) @(negedge clkcpu);
    endtask

    task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic host_wr(input logic [7:0] a, input logic [7:0] d);
        host_adr = a;
        host_din = d;
        host_we  = 1'b1;
        tick(1);
        host_we  = 1'b0;
        ref_mem[a] = d;
    endtask

    task automatic host_chk(input logic [7:0] a);
        host_adr = a;
        tick(2);
        check("host_rd", host_dout, ref_mem[a]);
    endtask

    task automatic i2c_start();
        sda_i = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_i = 1'b0; tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic i2c_stop();
        sda_i = 1'b0; tick(Q);
        scl_i = 1'b1; tick(Q);
        sda_i = 1'b1; tick(Q);
    endtask

    task automatic wr_bits(input logic [7:0] b, input int n);
        for (int i = 7; i > 7 - n; i--) begin
            sda_i = b[i]; tick(Q);
            scl_i = 1'b1; tick(2 * Q);
            scl_i = 1'b0; tick(Q);
        end
    endtask

    task automatic wr_byte(input logic [7:0] b, output logic ack);
        wr_bits(b, 8);
        sda_i = 1'b1; tick(Q);
        scl_i = 1'b1; tick(Q);
        ack = sda_o;  tick(Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic rd_byte(input logic nack, output logic [7:0] b);
        sda_i = 1'b1;
        for (int i = 7; i >= 0; i--) begin
            tick(Q);
            scl_i = 1'b1; tick(Q);
            b[i] = sda_o; tick(Q);
            scl_i = 1'b0;
        end
        tick(Q);
        sda_i = nack; tick(Q);
        scl_i = 1'b1; tick(2 * Q);
        scl_i = 1'b0; tick(Q);
    endtask

    task automatic i2c_write(input logic [7:0] a, input logic [7:0] d[$]);
        logic ak;
        i2c_start();
        wr_byte(8'hA0, ak); check("wr_dev_ack", ak, 8'h00);
        wr_byte(a, ak);     check("wr_word_ack", ak, 8'h00);
        ref_ptr = a;
        foreach (d[i]) begin
            wr_byte(d[i], ak); check("wr_data_ack", ak, 8'h00);
            ref_mem[ref_ptr] = d[i];
            ref_ptr = ref_ptr + 8'd1;
        end
        i2c_stop(); tick(Q);
        check("busy_after_stop", busy, 8'h00);
    endtask

    // Optionally sets the pointer first (write of the word address, then repeated START).
    task automatic i2c_read(input bit set_ptr, input logic [7:0] a, input int n);
        logic       ak;
        logic [7:0] b;
        if (set_ptr) begin
            i2c_start();
            wr_byte(8'hA0, ak); check("rd_set_dev_ack", ak, 8'h00);
            wr_byte(a, ak);     check("rd_set_word_ack", ak, 8'h00);
            ref_ptr = a;
        end
        i2c_start();
        wr_byte(8'hA1, ak); check("rd_dev_ack", ak, 8'h00);
        for (int i = 0; i < n; i++) begin
            rd_byte(i == n - 1, b);
            check("rd_data", b, ref_mem[ref_ptr]);
            ref_ptr = ref_ptr + 8'd1;
        end
        check("rd_release", sda_o, 8'h01);
        i2c_stop(); tick(Q);
        check("busy_after_stop", busy, 8'h00);
    endtask

    initial begin
        logic [7:0] q[$];
        logic [7:0] a;
        logic       ak;
        int         n;

        tick(4);
        check("rst_sda_o", sda_o, 8'h01);
        check("rst_busy", busy, 8'h00);
        check("rst_host_dout", host_dout, 8'h00);
        rst_n = 1'b1;
        tick(4);

        for (int i = 0; i < 256; i++) host_wr(8'(i), 8'($urandom));
        ref_ptr = 8'h00;

        // 1: preload, set pointer, repeated-START single-byte read
        host_wr(8'h10, 8'h5A);
        i2c_read(1'b1, 8'h10, 1);

        // 2: sequential write wrapping FF -> 00
        q.delete();
        q.push_back(8'h11); q.push_back(8'h22); q.push_back(8'h33);
        i2c_write(8'hFE, q);
        host_chk(8'hFE); host_chk(8'hFF); host_chk(8'h00);
        check("wrap_byte", host_dout, 8'h33);

        // 3: wrong device address, following bytes ignored
        i2c_start();
        wr_byte(8'hA2, ak); check("bad_dev_nack", ak, 8'h01);
        wr_byte(8'h10, ak); check("ign_nack0", ak, 8'h01);
        wr_byte(8'($urandom), ak); check("ign_nack1", ak, 8'h01);
        check("busy_ignore", busy, 8'h01);
        i2c_stop(); tick(Q);
        check("busy_after_ign", busy, 8'h00);
        host_chk(8'h10);

        // 4: partial data byte aborted by STOP; pointer left at the word address
        i2c_start();
        wr_byte(8'hA0, ak); check("part_dev_ack", ak, 8'h00);
        wr_byte(8'h20, ak); check("part_word_ack", ak, 8'h00);
        ref_ptr = 8'h20;
        wr_bits(~ref_mem[8'h20], 4);
        i2c_stop(); tick(Q);
        check("part_busy", busy, 8'h00);
        host_chk(8'h20);
        i2c_read(1'b0, 8'h00, 1);

        // 5: sequential read across 7F/80/81
        i2c_read(1'b1, 8'h7F, 3);

        // randomized write/read mix, away from the clock registers
        for (int t = 0; t < 6; t++) begin
            a = 8'(8 + $urandom_range(0, 240));
            n = $urandom_range(1, 4);
            if ($urandom_range(0, 1) == 1) begin
                q.delete();
                repeat (n) q.push_back(8'($urandom));
                i2c_write(a, q);
                for (int k = 0; k < n; k++) host_chk(8'(a + 8'(k)));
            end else begin
                i2c_read(1'b1, a, n);
            end
        end

`ifdef CMOS_RTC_TICK_EN
        // 6: one 1 Hz strobe rolls 23:59:59 to 00:00:00, suppressed by the stop bit
        rst_n = 1'b0; tick(3); rst_n = 1'b1;
        host_wr(8'h00, 8'h80);
        host_wr(8'h02, 8'h59); host_wr(8'h03, 8'h59); host_wr(8'h04, 8'h23);
        host_wr(8'h00, 8'h00);
        tick(140);
        host_wr(8'h00, 8'h80);
        host_adr = 8'h02; tick(2); check("rtc_sec", host_dout, 8'h00);
        host_adr = 8'h03; tick(2); check("rtc_min", host_dout, 8'h00);
        host_adr = 8'h04; tick(2); check("rtc_hour", host_dout, 8'h00);
        rst_n = 1'b0; tick(3); rst_n = 1'b1;
        host_wr(8'h00, 8'h80);
        host_wr(8'h02, 8'h59); host_wr(8'h03, 8'h59); host_wr(8'h04, 8'h23);
        tick(140);
        host_adr = 8'h02; tick(2); check("rtc_stop_sec", host_dout, 8'h59);
        host_adr = 8'h03; tick(2); check("rtc_stop_min", host_dout, 8'h59);
        host_adr = 8'h04; tick(2); check("rtc_stop_hour", host_dout, 8'h23);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmos_i2c_slave.md
Name: cmos_i2c_slave

Overview:
- I2C responder emulating the PCF8583 CMOS RAM/RTC on the IOC I2C bus. It is the far end of the IOC-driven I2C_CLOCK/I2C_DOUT/I2C_DIN lines.
- Holds 256 bytes of CMOS RAM with an auto-incrementing word pointer.
- Sits in the top level beside IOC; its sda_o is ANDed into I2C_DIN.
- A host port preloads CMOS contents from the HPS before the ARM leaves reset.

Parameters:
CLKCPU, 32000000, clkcpu frequency in Hz; used only by the optional RTC tick.
DEV_ADDR, 7'h50, 7-bit slave address (write 8'hA0, read 8'hA1).

Ports:
clkcpu  input  1  system clock; all logic on rising edge
rst_n  input  1  synchronous active-low reset
scl_i  input  1  I2C clock from master (IOC c_out[1])
sda_i  input  1  I2C data from master (IOC c_out[0])
sda_o  output  1  open-drain data; 0 = pull low, 1 = release; top level forms I2C_DIN = sda_i & sda_o
host_we  input  1  host preload write strobe, one clkcpu cycle
host_adr  input  8  host preload/readback address
host_din  input  8  host preload data
host_dout  output  8  RAM[host_adr], registered, 1-cycle latency
busy  output  1  high from START to STOP/abort

Behaviour:
- Reset, sampled when rst_n = 0 on a clkcpu edge: sda_o = 1, busy = 0, state = IDLE, pointer = 0, host_dout = 0. RAM contents are not cleared.
- Input conditioning: scl_i and sda_i each pass through a 2-flop synchroniser plus a 3-sample majority filter. Edges are detected on the filtered values.
- START: SDA falls while SCL is high. STOP: SDA rises while SCL is high. Both are recognised in any state.
  - START (including repeated start) -> DEVADDR, bit counter = 0, busy = 1.
  - STOP -> IDLE, sda_o = 1, busy = 0.
- Data is sampled on the SCL rising edge, MSB first. sda_o changes only on the SCL falling edge, except at reset/STOP.
- States:
  - IDLE: ignore the bus.
  - DEVADDR: shift 8 bits. If byte[7:1] == DEV_ADDR -> ACK_DEV. Otherwise -> IGNORE.
  - ACK_DEV: on the falling edge after bit 8, drive sda_o = 0 for one SCL period. Then R/W = 0 -> WORD; R/W = 1 -> load shift register with RAM[pointer] -> READ.
  - WORD: 8 bits -> pointer = byte -> ACK (sda_o = 0) -> WRITE.
  - WRITE: 8 bits -> RAM[pointer] = byte on the 8th rising edge -> ACK -> pointer + 1 -> WRITE.
  - READ: drive bits on falling edges. After 8 bits, release sda_o and sample the master ack on the 9th rising edge.
    - ACK (0): pointer + 1, reload from RAM[pointer], stay in READ.
    - NACK (1): -> IGNORE.
  - IGNORE: sda_o = 1; wait for START or STOP.
- Pointer is 8 bits and wraps 8'hFF -> 8'h00. Increment occurs after each completed data byte in both directions.
- RAM is a single-clock dual-port array: port A serves I2C, port B serves the host.
- Simultaneous host_we and I2C write to the same address: I2C wins. Host writes are intended only while busy = 0.
- START or STOP arriving mid-byte aborts the transfer. A partial byte is never written.
- rst_n low mid-transfer: bus released within one clkcpu cycle; next activity needs a fresh START.

Optional Feature:
- Macro: CMOS_RTC_TICK_EN.
- Defined:
  - A CLKCPU-cycle prescaler produces a 1 Hz strobe.
  - Each strobe increments RAM[2] (seconds, BCD 00-59). Rollover carries to RAM[3] (minutes, BCD 00-59), then RAM[4][5:0] (hours, BCD 00-23).
  - Counting is suppressed when RAM[0][7] (stop bit) = 1.
  - Updates occur only while busy = 0. A strobe during busy is held pending until busy falls.
- Undefined: RAM[0..7] are plain storage; no prescaler is synthesised.

Decomposition:
- Package cmos_pkg holds:
  - state enum (IDLE, DEVADDR, ACK_DEV, WORD, WRITE, READ, IGNORE);
  - DEV_ADDR default;
  - RTC register indices 2/3/4;
  - BCD limit constants 8'h59 and 8'h23.
- Sub-module i2c_cond: synchroniser, majority filter, and scl_rise/scl_fall/start/stop pulse generation. It is reused for the keyboard line later.

Test Plan:
1. Preload via host_we: adr 8'h10 = 8'h5A. Bus: START, A0, 10, repeated START, A1, read one byte with NACK, STOP -> bytes 1-2 ACKed; read byte = 8'h5A; busy = 0 after STOP.
2. START, A0, FE, 11, 22, 33, STOP -> RAM[FE] = 11, RAM[FF] = 22, RAM[00] = 33 (wrap); host_dout at adr 8'h00 = 8'h33.
3. START, A2 (wrong address) -> sda_o stays 1 for the ack bit; the following bytes are ignored; RAM unchanged.
4. Write A0, 20, then 4 data bits, then STOP -> RAM[20] unchanged; pointer = 8'h20; state IDLE.
5. Sequential read A1 from pointer 8'h7F with master ACK ×2, then NACK -> returns RAM[7F], RAM[80], RAM[81]; sda_o released after the NACK.
6. (CMOS_RTC_TICK_EN, CLKCPU = 100) RAM[2] = 59, RAM[3] = 59, RAM[4] = 23; run 100 cycles -> all three = 00. Repeat with RAM[0] = 8'h80 -> values unchanged.
